// File: rtl/demux1x2_stream_nbit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : demux1x2_stream_nbit_pkg
//  Description : Select encoding shared with the 2:1 stream mux.
//  Revision    : 1.0 - initial release
// ============================================================================
package demux1x2_stream_nbit_pkg;

    localparam logic SEL_A = 1'b1;
    localparam logic SEL_B = 1'b0;

endpackage : demux1x2_stream_nbit_pkg
`default_nettype wire

// File: rtl/demux1x2_stream_nbit_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo_nbit
//  Description : Single-clock FIFO with occupancy counter; head zeroed when empty.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo_nbit #(
    parameter  int N     = 4,
    parameter  int DEPTH = 2,
    localparam int LW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [N-1:0]  push_data,
    input  logic          pop,
    output logic [N-1:0]  head_data,
    output logic          empty,
    output logic          full,
    output logic [LW-1:0] level
);

    localparam int AW = $clog2(DEPTH);

    logic [N-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [LW-1:0] r_level;
    logic          w_push_ok;
    logic          w_pop_ok;

    assign empty     = (r_level == '0);
    assign full      = (r_level == LW'(DEPTH));
    assign level     = r_level;
    // A full FIFO refuses a push even when it pops in the same cycle.
    assign w_push_ok = push & ~full;
    assign w_pop_ok  = pop & ~empty;
    assign head_data = empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            unique case ({w_push_ok, w_pop_ok})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule : sync_fifo_nbit
`default_nettype wire

// File: rtl/demux1x2_stream_nbit.sv
`default_nettype none
// ============================================================================
//  Module      : demux1x2_stream_nbit
//  Description : Routes one valid/ready stream into per-channel FIFOs A/B.
//  Revision    : 1.0 - initial release
// ============================================================================
module demux1x2_stream_nbit
    import demux1x2_stream_nbit_pkg::*;
#(
    parameter  int N     = 4,
    parameter  int DEPTH = 2,
    localparam int LW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  in_data,
    input  logic          in_sel,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [N-1:0]  a_data,
    output logic          a_valid,
    input  logic          a_ready,
    output logic [LW-1:0] a_level,
    output logic [N-1:0]  b_data,
    output logic          b_valid,
    input  logic          b_ready,
    output logic [LW-1:0] b_level
);

    logic w_a_full;
    logic w_b_full;
    logic w_a_empty;
    logic w_b_empty;
    logic w_push_a;
    logic w_push_b;

    // Depends only on the fill state, never on a_ready/b_ready.
    assign in_ready = (in_sel == SEL_A) ? ~w_a_full : ~w_b_full;
    assign w_push_a = in_valid & in_ready & (in_sel == SEL_A);
    assign w_push_b = in_valid & in_ready & (in_sel == SEL_B);
    assign a_valid  = ~w_a_empty;
    assign b_valid  = ~w_b_empty;

    sync_fifo_nbit #(
        .N     (N),
        .DEPTH (DEPTH)
    ) u_fifo_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (w_push_a),
        .push_data (in_data),
        .pop       (a_ready),
        .head_data (a_data),
        .empty     (w_a_empty),
        .full      (w_a_full),
        .level     (a_level)
    );

    sync_fifo_nbit #(
        .N     (N),
        .DEPTH (DEPTH)
    ) u_fifo_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (w_push_b),
        .push_data (in_data),
        .pop       (b_ready),
        .head_data (b_data),
        .empty     (w_b_empty),
        .full      (w_b_full),
        .level     (b_level)
    );

endmodule : demux1x2_stream_nbit
`default_nettype wire

// File: tb/tb_demux1x2_stream_nbit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_demux1x2_stream_nbit
//  Description : Scoreboard bench for the 1:2 stream demux (N=4, DEPTH=2).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_demux1x2_stream_nbit;

    localparam int N     = 4;
    localparam int DEPTH = 2;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  in_data;
    logic          in_sel;
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  a_data;
    logic          a_valid;
    logic          a_ready;
    logic [LW-1:0] a_level;
    logic [N-1:0]  b_data;
    logic          b_valid;
    logic          b_ready;
    logic [LW-1:0] b_level;

    int n_checks = 0;
    int n_pass   = 0;
    logic [N-1:0] q_a[$];
    logic [N-1:0] q_b[$];

    always #5 clk = ~clk;

    demux1x2_stream_nbit #(.N(N), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .in_sel   (in_sel),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a_data   (a_data),
        .a_valid  (a_valid),
        .a_ready  (a_ready),
        .a_level  (a_level),
        .b_data   (b_data),
        .b_valid  (b_valid),
        .b_ready  (b_ready),
        .b_level  (b_level)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: evaluates handshakes mid-cycle, ahead of the edge that commits them.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            chk("a_level_bound", 32'(a_level <= LW'(DEPTH)), 32'd1);
            chk("b_level_bound", 32'(b_level <= LW'(DEPTH)), 32'd1);
            chk("a_valid_vs_level", 32'(a_valid), 32'(a_level != '0));
            chk("b_valid_vs_level", 32'(b_valid), 32'(b_level != '0));
            if (!a_valid) chk("a_data_empty_zero", 32'(a_data), 32'd0);
            if (!b_valid) chk("b_data_empty_zero", 32'(b_data), 32'd0);
            if (a_valid && a_ready) begin
                if (q_a.size() == 0) chk("a_unexpected_beat", 32'(a_data), 32'hFFFF_FFFF);
                else chk("a_order", 32'(a_data), 32'(q_a.pop_front()));
            end
            if (b_valid && b_ready) begin
                if (q_b.size() == 0) chk("b_unexpected_beat", 32'(b_data), 32'hFFFF_FFFF);
                else chk("b_order", 32'(b_data), 32'(q_b.pop_front()));
            end
            if (in_valid && in_ready) begin
                if (in_sel) q_a.push_back(in_data);
                else        q_b.push_back(in_data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int budget;
        logic acc;
        rst_n    = 1'b0;
        in_data  = '0;
        in_sel   = 1'b0;
        in_valid = 1'b0;
        a_ready  = 1'b0;
        b_ready  = 1'b0;
        repeat (3) step();
        chk("rst_a_valid", 32'(a_valid), 32'd0);
        chk("rst_b_valid", 32'(b_valid), 32'd0);
        chk("rst_a_level", 32'(a_level), 32'd0);
        chk("rst_b_level", 32'(b_level), 32'd0);
        chk("rst_b_data", 32'(b_data), 32'd0);
        rst_n = 1'b1;
        step();

        // Asynchronous reset with two beats parked in A.
        in_valid = 1'b1; in_sel = 1'b1; in_data = 4'h7;
        step();
        in_data = 4'h8;
        step();
        in_valid = 1'b0;
        chk("pre_rst_a_level", 32'(a_level), 32'd2);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_a_valid", 32'(a_valid), 32'd0);
        chk("async_rst_a_level", 32'(a_level), 32'd0);
        chk("async_rst_a_data", 32'(a_data), 32'd0);
        q_a.delete();
        q_b.delete();
        step();
        rst_n = 1'b1;
        in_valid = 1'b1; in_sel = 1'b1; in_data = 4'h5;
        step();
        in_valid = 1'b0;
        chk("post_rst_a_valid", 32'(a_valid), 32'd1);
        chk("post_rst_a_data", 32'(a_data), 32'h5);
        chk("post_rst_a_level", 32'(a_level), 32'd1);
        a_ready = 1'b1;
        step();
        chk("post_rst_drain", 32'(a_level), 32'd0);

        // Routing with both consumers ready.
        b_ready = 1'b1;
        in_valid = 1'b1; in_sel = 1'b1; in_data = 4'h3;
        #1 chk("route_a_ready", 32'(in_ready), 32'd1);
        step();
        in_sel = 1'b0; in_data = 4'hC;
        chk("route_a_valid", 32'(a_valid), 32'd1);
        chk("route_a_data", 32'(a_data), 32'h3);
        chk("route_b_empty", 32'(b_valid), 32'd0);
        step();
        in_valid = 1'b0;
        chk("route_a_level0", 32'(a_level), 32'd0);
        chk("route_b_valid", 32'(b_valid), 32'd1);
        chk("route_b_data", 32'(b_data), 32'hC);
        step();
        chk("route_b_level0", 32'(b_level), 32'd0);

        // Backpressure on A while B keeps flowing.
        a_ready = 1'b0;
        in_valid = 1'b1; in_sel = 1'b1; in_data = 4'h1;
        step();
        in_data = 4'h2;
        step();
        in_valid = 1'b0;
        chk("bp_a_level_full", 32'(a_level), 32'd2);
        #1 chk("bp_ready_sel_a", 32'(in_ready), 32'd0);
        in_sel = 1'b0;
        #1 chk("bp_ready_sel_b", 32'(in_ready), 32'd1);
        in_valid = 1'b1; in_data = 4'h9;
        step();
        in_valid = 1'b0;
        chk("bp_b_valid", 32'(b_valid), 32'd1);
        chk("bp_b_data", 32'(b_data), 32'h9);

        // Full FIFO refuses a push in the cycle it pops.
        a_ready = 1'b1;
        in_valid = 1'b1; in_sel = 1'b1; in_data = 4'hE;
        #1 chk("full_pop_in_ready", 32'(in_ready), 32'd0);
        step();
        chk("full_pop_a_level", 32'(a_level), 32'd1);
        chk("full_pop_a_head", 32'(a_data), 32'h2);
        chk("full_pop_in_ready_next", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        chk("pushpop_a_level", 32'(a_level), 32'd1);
        chk("pushpop_a_head", 32'(a_data), 32'hE);
        step();
        chk("full_pop_drained", 32'(a_level), 32'd0);

        // Wrap-around: 20 beats to B against a random consumer.
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1; in_sel = 1'b0; in_data = N'(i);
            budget = 0;
            acc = 1'b0;
            while (!acc && budget < 200) begin
                b_ready = 1'($urandom_range(0, 1));
                #1 acc = in_ready;
                step();
                budget++;
            end
            if (!acc) chk("wrap_accept_timeout", 32'(i), 32'hFFFF_FFFF);
        end
        in_valid = 1'b0;
        b_ready  = 1'b1;
        budget = 0;
        while (b_level != '0 && budget < 50) begin
            step();
            budget++;
        end
        chk("wrap_drain_level", 32'(b_level), 32'd0);
        step();
        chk("end_q_a_empty", 32'(q_a.size()), 32'd0);
        chk("end_q_b_empty", 32'(q_b.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_demux1x2_stream_nbit
`default_nettype wire

// File: doc/demux1x2_stream_nbit.md
Name: demux1x2_stream_nbit

Overview:
- Routes one N-bit valid/ready input stream to one of two buffered output channels, A or B, using a per-beat select.
- It is the inverse of the team's 2:1 mux.
- Select convention matches the mux: sel=1 routes to A, sel=0 routes to B.
- Each channel has its own small synchronous FIFO. A stalled consumer on one channel never corrupts or reorders the other channel.

Parameters:
- N, 4, data width in bits (>=1).
- DEPTH, 2, entries per output FIFO (power of 2, >=2).
- LW, $clog2(DEPTH)+1, level-counter width (derived localparam, not overridable).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_data  input  N  input beat.
- in_sel  input  1  destination of the current beat: 1 routes to A, 0 routes to B.
- in_valid  input  1  beat present on in_data/in_sel.
- in_ready  output  1  block can accept the beat at its current in_sel.
- a_data  output  N  head of FIFO A.
- a_valid  output  1  FIFO A non-empty.
- a_ready  input  1  consumer A takes the head this cycle.
- a_level  output  LW  FIFO A occupancy (0..DEPTH).
- b_data  output  N  head of FIFO B.
- b_valid  output  1  FIFO B non-empty.
- b_ready  input  1  consumer B takes the head this cycle.
- b_level  output  LW  FIFO B occupancy.

Behaviour:
- Single clock domain is clk. Reset is asynchronous and active-low on rst_n.
- Reset asserted at any time, including mid-transfer:
  - a_valid, b_valid = 0.
  - a_level, b_level = 0.
  - All pointers = 0.
  - a_data and b_data are driven as 0 while empty.
  - Buffered contents are discarded.
- in_ready is combinational:
  - in_sel=1: in_ready = ~full_A.
  - in_sel=0: in_ready = ~full_B.
  - No combinational path exists from a_ready or b_ready to in_ready. A full FIFO refuses a push even if it is popping in the same cycle.
- Input accept: in_valid & in_ready at the clk edge pushes {in_data} into the FIFO chosen by in_sel.
- Upstream rules: in_valid must not depend on in_ready. in_data and in_sel must hold stable while in_valid=1 and the beat is unaccepted.
- Latency: a beat accepted at edge k appears on x_valid/x_data immediately after edge k. There is no combinational bypass from input to output.
- Output pop: x_valid & x_ready at a clk edge removes the head. x_ready while x_valid=0 is ignored.
- Simultaneous push and pop on the same FIFO: occupancy is unchanged and order is preserved.
  - On a FIFO holding 1 entry, the pushed beat becomes the new head after the edge.
- Pushes to A and pops from B (or the reverse) in the same cycle are independent.
- Pointers are log2(DEPTH) bits and wrap naturally modulo DEPTH.
- Occupancy is tracked by an LW-bit counter:
  - full = (level == DEPTH).
  - empty = (level == 0).
  - Counter never exceeds DEPTH and never underflows.
- x_data shows the head entry whenever x_valid=1. x_data is 0 when the FIFO is empty.
- Order within each channel is FIFO. There is no ordering guarantee between channels.
- No state machine beyond the FIFO counters. Behaviour is fully defined by push/pop/level.

Decomposition:
- No shared package is required.
- LW is computed locally.
- The select encoding (SEL_A=1'b1, SEL_B=1'b0) goes in the team's common defines include so it stays consistent with mux2x1_nbit.
- Natural sub-module: sync_fifo_nbit (parameters N, DEPTH):
  - Ports: clk, rst_n, push, push_data, pop, head_data, empty, full, level.
  - Instantiated twice.
- The top contains only the in_ready and push-steering logic.

Test Plan:
- Reset: assert rst_n=0 mid-stream with A holding 2 beats -> a_valid=0, a_level=0, a_data=0 immediately (asynchronously). After release, first push 4'h5 (sel=1) appears on A the next cycle.
- Routing: send 4'h3 (sel=1), then 4'hC (sel=0), with both readies=1 -> A delivers 3 and B delivers C, each exactly one cycle after acceptance. Levels return to 0.
- Backpressure, DEPTH=2: a_ready=0, push 1,2 to A -> a_level=2, and in_ready=0 while in_sel=1 but 1 while in_sel=0. Push 4'h9 to B succeeds. Release a_ready -> A outputs 1 then 2.
- Full with simultaneous pop: A full {1,2}, a_ready=1, in_valid=1, sel=1 -> no accept that cycle (in_ready=0). Next cycle level=1, accept occurs, and order 1,2,new is preserved.
- Wrap-around: stream 20 beats 0..F,0..3 to B with random b_ready -> B outputs exactly the same sequence. b_level stays in 0..2 and never exceeds DEPTH.
